// File: rtl/rank_pkg.sv
// Shared types and helpers for the ranking blocks (max / second-largest trackers, drain queue).
package rank_pkg;
  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/pq_slot.sv
// One storage slot of the sorted queue; picks its next value from itself, its neighbours or din.
module pq_slot #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] prev,
  input  logic [DATA_WIDTH-1:0] next,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  here,
  input  logic                  above,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] value
);
  logic [DATA_WIDTH-1:0] value_next;

  // With a pop the post-pop order is slot[i+1], so "own" plays the role of the shifted-up neighbour.
  always_comb begin
    value_next = value;
    if (clear)
      value_next = '0;
    else if (push && pop)
      value_next = here ? (above ? value : din) : next;
    else if (push)
      value_next = here ? (above ? prev : din) : value;
    else if (pop)
      value_next = next;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      value <= '0;
    else
      value <= value_next;
  end
endmodule

// File: rtl/max_drain_queue.sv
// Max-first priority queue: a sorted shift register of DEPTH slots with valid/ready on both sides.
module max_drain_queue
  import rank_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      clear,
  input  logic [DATA_WIDTH-1:0]     din,
  input  logic                      din_valid,
  output logic                      din_ready,
  output logic [DATA_WIDTH-1:0]     dout,
  output logic                      dout_valid,
  input  logic                      dout_ready,
  output logic [cnt_w(DEPTH)-1:0]   count
);
  localparam int CW = cnt_w(DEPTH);

  logic [DATA_WIDTH-1:0] slot [DEPTH];
  logic [DEPTH-1:0]      ge_push;
  logic [DEPTH-1:0]      ge_pp;
  logic                  push;
  logic                  pop;

  assign push       = din_valid & din_ready;
  assign pop        = dout_valid & dout_ready;
  assign dout       = slot[0];
  assign dout_valid = (count != '0);
  assign din_ready  = (count != CW'(DEPTH));

  // ge_* marks slots at or past the insertion point; monotone because slots stay sorted.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [DATA_WIDTH-1:0] prev;
    logic [DATA_WIDTH-1:0] next;
    logic                  here;
    logic                  above;

    if (i == 0) begin : g_top
      assign prev  = '0;
      assign above = 1'b0;
    end else begin : g_mid
      assign prev  = slot[i-1];
      assign above = pop ? ge_pp[i-1] : ge_push[i-1];
    end

    if (i == DEPTH - 1) begin : g_last
      assign next = '0;
    end else begin : g_inner
      assign next = slot[i+1];
    end

    assign ge_push[i] = (i >= int'(count)) || (din > slot[i]);
    assign ge_pp[i]   = ((i + 1) >= int'(count)) || (din > next);
    assign here       = pop ? ge_pp[i] : ge_push[i];

    pq_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
      .clk    (clk),
      .resetn (resetn),
      .prev   (prev),
      .next   (next),
      .din    (din),
      .here   (here),
      .above  (above),
      .push   (push),
      .pop    (pop),
      .clear  (clear),
      .value  (slot[i])
    );
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (push && !pop)
      count <= count + CW'(1);
    else if (pop && !push)
      count <= count - CW'(1);
  end
endmodule

// File: tb/tb_max_drain_queue.sv
// Directed bench for max_drain_queue: a per-cycle vector table plus an asynchronous-reset sequence.
module tb_max_drain_queue;
  logic        clk;
  logic        resetn;
  logic        clear;
  logic [31:0] din;
  logic        din_valid;
  logic        din_ready;
  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic [3:0]  count;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic        dv;
    logic [31:0] d;
    logic        dr;
    logic        clr;
    logic [31:0] ed;
    logic        ev;
    int          ec;
    logic        er;
  } vec_t;

  vec_t vecs[$];

  max_drain_queue #(.DATA_WIDTH(32), .DEPTH(8)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .clear      (clear),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [31:0] ed, input logic ev,
                             input int ec, input logic er);
    check({tag, " dout"}, dout, ed);
    check({tag, " dout_valid"}, {31'd0, dout_valid}, {31'd0, ev});
    check({tag, " count"}, {28'd0, count}, ec);
    check({tag, " din_ready"}, {31'd0, din_ready}, {31'd0, er});
  endtask

  task automatic add(input logic dv, input logic [31:0] d, input logic dr, input logic clr,
                     input logic [31:0] ed, input logic ev, input int ec, input logic er);
    vec_t v;
    v.dv = dv; v.d = d; v.dr = dr; v.clr = clr;
    v.ed = ed; v.ev = ev; v.ec = ec; v.er = er;
    vecs.push_back(v);
  endtask

  task automatic step(input logic dv, input logic [31:0] d, input logic dr, input logic clr);
    @(negedge clk);
    din_valid = dv; din = d; dout_ready = dr; clear = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    resetn = 1'b0; clear = 1'b0; din = '0; din_valid = 1'b0; dout_ready = 1'b0;

    // push 5,9,1,9 then drain 9,9,5,1
    add(1, 5, 0, 0,  5, 1, 1, 1);
    add(1, 9, 0, 0,  9, 1, 2, 1);
    add(1, 1, 0, 0,  9, 1, 3, 1);
    add(1, 9, 0, 0,  9, 1, 4, 1);
    add(0, 0, 1, 0,  9, 1, 3, 1);
    add(0, 0, 1, 0,  5, 1, 2, 1);
    add(0, 0, 1, 0,  1, 1, 1, 1);
    add(0, 0, 1, 0,  0, 0, 0, 1);
    // fill with 10..17, reject 99 while full, pop once
    for (int k = 0; k < 8; k++)
      add(1, 32'(10 + k), 0, 0, 32'(10 + k), 1, k + 1, (k != 7));
    add(1, 99, 0, 0, 17, 1, 8, 0);
    add(1, 99, 1, 0, 16, 1, 7, 1);
    add(0, 0, 0, 1,  0, 0, 0, 1);
    // {7,3}: push 5 with pop
    add(1, 7, 0, 0,  7, 1, 1, 1);
    add(1, 3, 0, 0,  7, 1, 2, 1);
    add(1, 5, 1, 0,  5, 1, 2, 1);
    add(0, 0, 1, 0,  3, 1, 1, 1);
    add(0, 0, 1, 0,  0, 0, 0, 1);
    // {4}: push 20 with pop; then push+pop on empty
    add(1, 4, 0, 0,  4, 1, 1, 1);
    add(1, 20, 1, 0, 20, 1, 1, 1);
    add(0, 0, 1, 0,  0, 0, 0, 1);
    add(1, 6, 1, 0,  6, 1, 1, 1);
    add(0, 0, 1, 0,  0, 0, 0, 1);
    // {30,2,2}: clear wins over push 50
    add(1, 30, 0, 0, 30, 1, 1, 1);
    add(1, 2, 0, 0,  30, 1, 2, 1);
    add(1, 2, 0, 0,  30, 1, 3, 1);
    add(1, 50, 0, 1,  0, 0, 0, 1);
    add(0, 0, 0, 0,  0, 0, 0, 1);

    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 0, 0, 0, 1);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].dv, vecs[i].d, vecs[i].dr, vecs[i].clr);
      check_state($sformatf("vec%0d", i), vecs[i].ed, vecs[i].ev, vecs[i].ec, vecs[i].er);
    end

    // asynchronous reset with six entries stored
    for (int k = 0; k < 6; k++)
      step(1, 32'(100 + k), 0, 0);
    check_state("pre_async", 105, 1, 6, 1);
    @(negedge clk);
    din_valid = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    check_state("async_rst", 0, 0, 0, 1);
    @(negedge clk);
    resetn = 1'b1;

    step(1, 32'hFFFF_FFFF, 0, 0);
    check_state("push_ones", 32'hFFFF_FFFF, 1, 1, 1);
    step(1, 32'h0, 0, 0);
    check_state("push_zero", 32'hFFFF_FFFF, 1, 2, 1);
    step(0, 0, 1, 0);
    check_state("pop_ones", 32'h0, 1, 1, 1);
    step(0, 0, 1, 0);
    check_state("pop_zero", 32'h0, 0, 0, 1);

    @(negedge clk);
    dout_ready = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
